// File: rtl/router_pkg.sv
// Shared types for the row router.
//   rr_state_t      : routing FSM states.
//   rr_addr_entry_t : one address FIFO entry ({addr, last}); addr is stored
//                     at a fixed maximum width and narrowed by the user.
//   rr_cnt_width    : occupancy counter width for a FIFO of a given depth
//                     (one extra bit so that "full" is representable).
package router_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DRAIN,
      DONE
   } rr_state_t;

   localparam int unsigned RR_ADDR_MAX_W = 16;

   typedef struct packed {
      logic [RR_ADDR_MAX_W-1:0] addr;
      logic                     last;
   } rr_addr_entry_t;

   function automatic int unsigned rr_cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/row_router_sync_fifo.sv
// Synchronous FIFO with registered storage and no bypass.
//   i_clk, i_nrst (sync, active-low), i_clr (sync clear, same effect as reset)
//   i_push / i_din : write; ignored when full
//   i_pop          : read; ignored when empty
//   o_dout         : head entry, forced to 0 when empty
//   o_empty        : no entries held
//   o_count        : occupancy, 0..DEPTH
// DEPTH must be a power of 2 and at least 2.
module sync_fifo
   import router_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = rr_cnt_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Pointers carry one wrap bit above the index to tell full from empty.
   logic [PW:0]      wptr_q, wptr_d;
   logic [PW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign o_empty = (wptr_q == rptr_q);
   assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign o_count = wptr_q - rptr_q;
   assign push_ok = i_push & ~full;
   assign pop_ok  = i_pop & ~o_empty;
   assign o_dout  = o_empty ? '0 : mem_q[rptr_q[PW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst || i_clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wptr_q[PW-1:0]] <= i_din;
   end

endmodule

// File: rtl/row_router.sv
// Per-row routing stage behind the data selector.
//   i_clk, i_nrst (sync, active-low), i_en (enable), i_reg_clear (sync clear)
//   i_addr_valid/i_addr/i_addr_last/o_addr_ready : address enqueue
//   o_rr_valid_addr/o_rr_addr                    : head address to selector
//   i_rr_data_hit/i_rr_data                      : selector hit, data one cycle later
//   o_stall                                      : throttles the selector
//   i_data_ready/o_data_valid/o_data/o_data_count: data FIFO drain by array row
//   o_done                                       : one-cycle end-of-tile pulse
module row_router
   import router_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned BUF_DEPTH  = 64,
   parameter  int unsigned FIFO_DEPTH = 16,
   localparam int unsigned ADDR_WIDTH = $clog2(BUF_DEPTH),
   localparam int unsigned CNT_WIDTH  = rr_cnt_width(FIFO_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_en,
   input  logic                  i_reg_clear,
   input  logic                  i_addr_valid,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_addr_last,
   output logic                  o_addr_ready,
   output logic                  o_rr_valid_addr,
   output logic [ADDR_WIDTH-1:0] o_rr_addr,
   input  logic                  i_rr_data_hit,
   input  logic [DATA_WIDTH-1:0] i_rr_data,
   output logic                  o_stall,
   input  logic                  i_data_ready,
   output logic                  o_data_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CNT_WIDTH-1:0]  o_data_count,
   output logic                  o_done
);

   rr_state_t             state_q, state_d;
   logic                  last_seen_q, last_seen_d;
   logic                  hit_d1_q, hit_d1_d;
   logic [ADDR_WIDTH:0]   addr_din, addr_dout;
   logic                  addr_empty, data_empty;
   logic [CNT_WIDTH-1:0]  addr_count, data_count;
   logic                  push_addr, pop_addr;
   rr_addr_entry_t        head;

   assign addr_din  = {i_addr, i_addr_last};
   assign head      = '{addr: RR_ADDR_MAX_W'(addr_dout[ADDR_WIDTH:1]), last: addr_dout[0]};

   // Ready is taken from the registered count, so a pop in the full cycle
   // does not make room for a push in that same cycle.
   assign o_addr_ready    = (addr_count != CNT_WIDTH'(FIFO_DEPTH));
   assign o_rr_valid_addr = ~addr_empty;
   assign o_rr_addr       = ADDR_WIDTH'(head.addr);
   assign push_addr       = i_addr_valid & o_addr_ready;

   // Counting the in-flight hit guarantees the delayed push always has room.
   assign o_stall = ~i_en | (state_q != ROUTE)
                  | ((32'(data_count) + 32'(hit_d1_q)) >= FIFO_DEPTH);

   assign pop_addr = i_rr_data_hit & ~addr_empty & ~o_stall;
   assign hit_d1_d = pop_addr;

   sync_fifo #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_clr   (i_reg_clear),
      .i_push  (push_addr),
      .i_din   (addr_din),
      .i_pop   (pop_addr),
      .o_dout  (addr_dout),
      .o_empty (addr_empty),
      .o_count (addr_count)
   );

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_data_fifo (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_clr   (i_reg_clear),
      .i_push  (hit_d1_q),
      .i_din   (i_rr_data),
      .i_pop   (i_data_ready),
      .o_dout  (o_data),
      .o_empty (data_empty),
      .o_count (data_count)
   );

   assign o_data_valid = ~data_empty;
   assign o_data_count = data_count;
   assign o_done       = (state_q == DONE);

   always_comb begin
      state_d     = state_q;
      last_seen_d = last_seen_q;
      if (pop_addr && head.last) last_seen_d = 1'b1;
      unique case (state_q)
         IDLE:  if (i_en) state_d = ROUTE;
         // last_seen lags the final pop by one cycle, so leaving ROUTE here
         // lets that pop's data push complete first.
         ROUTE: if (i_en && last_seen_q) state_d = DRAIN;
         DRAIN: if (data_empty) state_d = DONE;
         DONE: begin
            last_seen_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst || i_reg_clear) begin
         state_q     <= IDLE;
         last_seen_q <= 1'b0;
         hit_d1_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_seen_q <= last_seen_d;
         hit_d1_q    <= hit_d1_d;
      end
   end

endmodule

// File: tb/tb_row_router.sv
module tb_row_router;

   localparam int DEPTH = 16;
   localparam int M_IDLE = 0, M_ROUTE = 1, M_DRAIN = 2, M_DONE = 3;

   logic       i_clk = 1'b0;
   logic       i_nrst, i_en, i_reg_clear, i_addr_valid, i_addr_last;
   logic [5:0] i_addr;
   logic       o_addr_ready, o_rr_valid_addr, o_stall, o_data_valid, o_done;
   logic [5:0] o_rr_addr;
   logic       i_rr_data_hit, i_data_ready;
   logic [7:0] i_rr_data, o_data;
   logic [4:0] o_data_count;

   row_router #(.DATA_WIDTH(8), .BUF_DEPTH(64), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_en(i_en), .i_reg_clear(i_reg_clear),
      .i_addr_valid(i_addr_valid), .i_addr(i_addr), .i_addr_last(i_addr_last),
      .o_addr_ready(o_addr_ready), .o_rr_valid_addr(o_rr_valid_addr),
      .o_rr_addr(o_rr_addr), .i_rr_data_hit(i_rr_data_hit), .i_rr_data(i_rr_data),
      .o_stall(o_stall), .i_data_ready(i_data_ready), .o_data_valid(o_data_valid),
      .o_data(o_data), .o_data_count(o_data_count), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: address queue, expected data queue (the scoreboard),
   // in-flight hit flag, tile-last flag and routing phase.
   typedef struct { logic [5:0] a; bit l; } ent_t;
   ent_t       aq[$];
   logic [7:0] exp_q[$];
   bit         pend, ls, clr_flag;
   int         mode;
   int         n_cmp = 0, n_bad = 0;
   logic [5:0] prev_a = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: every data FIFO pop is compared with the scoreboard head.
   always @(negedge i_clk) begin
      if (o_data_valid === 1'b1 && i_data_ready === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL data_pop: got %0h expected nothing at %0t", o_data, $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               n_bad++;
               $display("FAIL data_pop: got %0h expected %0h at %0t", o_data, e, $time);
            end
         end
      end
   end

   task automatic step(input bit nrst, input bit clr, input bit en, input bit av,
                       input logic [5:0] a, input bit l, input bit hit,
                       input logic [7:0] d, input bit dr);
      int cnt;
      bit stall, pop, push;
      cnt = exp_q.size();
      chk("addr_ready", o_addr_ready, aq.size() < DEPTH);
      chk("rr_valid_addr", o_rr_valid_addr, aq.size() != 0);
      chk("rr_addr", o_rr_addr, aq.size() != 0 ? aq[0].a : 6'd0);
      chk("data_count", o_data_count, cnt);
      chk("data_valid", o_data_valid, cnt != 0);
      if (cnt == 0) chk("data_zero", o_data, 0);
      chk("done", o_done, mode == M_DONE);
      i_nrst = nrst; i_reg_clear = clr; i_en = en; i_addr_valid = av;
      i_addr = a; i_addr_last = l; i_rr_data_hit = hit; i_rr_data = d;
      i_data_ready = dr;
      #1;
      stall = !en || mode != M_ROUTE || (cnt + int'(pend) >= DEPTH);
      chk("stall", o_stall, stall);
      if (!nrst || clr) begin
         aq.delete(); pend = 0; ls = 0; mode = M_IDLE; clr_flag = 1;
      end else begin
         pop  = hit && aq.size() != 0 && !stall;
         push = av && aq.size() < DEPTH;
         if (pend) exp_q.push_back(d);
         case (mode)
            M_IDLE:  if (en) mode = M_ROUTE;
            M_ROUTE: if (en && ls) mode = M_DRAIN;
            M_DRAIN: if (cnt == 0) mode = M_DONE;
            default: begin ls = 0; mode = M_IDLE; end
         endcase
         if (pop && aq[0].l) ls = 1;
         if (pop) void'(aq.pop_front());
         if (push) aq.push_back('{a, l});
         pend = pop;
      end
      @(posedge i_clk); #1;
      if (clr_flag) begin exp_q.delete(); clr_flag = 0; end
   endtask

   task automatic idle(input int n, input bit en, input bit dr);
      for (int k = 0; k < n; k++) step(1, 0, en, 0, 0, 0, 0, 8'($urandom), dr);
   endtask

   task automatic rand_steps(input int n, input int p_av, input int p_hit, input int p_dr,
                             input int p_en, input int p_last, input int p_clr, input int p_rst);
      for (int k = 0; k < n; k++) begin
         logic [5:0] a;
         a = 6'($urandom_range(0, 63));
         if (a == prev_a) a = a + 6'd1;
         prev_a = a;
         step(!($urandom_range(0, 999) < p_rst), $urandom_range(0, 999) < p_clr,
              $urandom_range(0, 99) < p_en, $urandom_range(0, 99) < p_av, a,
              $urandom_range(0, 99) < p_last, $urandom_range(0, 99) < p_hit,
              8'($urandom), $urandom_range(0, 99) < p_dr);
      end
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      i_nrst = 0; i_en = 0; i_reg_clear = 0; i_addr_valid = 0; i_addr = '0;
      i_addr_last = 0; i_rr_data_hit = 0; i_rr_data = '0; i_data_ready = 0;
      mode = M_IDLE; pend = 0; ls = 0; clr_flag = 0;
      @(posedge i_clk); #1;

      // Basic tile: addrs 3,7,9 (last on 9), data A1,B2,C3, then drain and done.
      step(1, 0, 1, 1, 6'd3, 0, 0, 8'h00, 1);
      step(1, 0, 1, 1, 6'd7, 0, 0, 8'h00, 1);
      step(1, 0, 1, 1, 6'd9, 1, 0, 8'h00, 1);
      step(1, 0, 1, 0, 0, 0, 1, 8'h00, 1);
      step(1, 0, 1, 0, 0, 0, 1, 8'hA1, 1);
      step(1, 0, 1, 0, 0, 0, 1, 8'hB2, 1);
      step(1, 0, 1, 0, 0, 0, 0, 8'hC3, 1);
      idle(8, 1, 1);

      // Address FIFO fill, overflow attempts, pop+push while full.
      do_reset();
      rand_steps(30, 95, 0, 100, 100, 0, 0, 0);
      rand_steps(6, 100, 100, 100, 100, 0, 0, 0);

      // Hits while disabled, then resume.
      rand_steps(8, 20, 100, 100, 0, 0, 0, 0);
      rand_steps(6, 20, 100, 100, 100, 0, 0, 0);

      // Data FIFO fill to the stall threshold with no drain, then release.
      rand_steps(40, 70, 90, 0, 100, 0, 0, 0);
      rand_steps(3, 0, 100, 0, 100, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 1, 8'h5A, 1);
      rand_steps(30, 50, 80, 100, 100, 0, 0, 0);

      // Clear with 5 addresses, 4 data entries and one hit in flight.
      do_reset();
      step(1, 0, 1, 1, 6'd10, 0, 0, 0, 0);
      for (int k = 1; k < 10; k++) step(1, 0, 1, 1, 6'(10 + k), 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0, 0, 1, 8'(8'h40 + k), 0);
      step(1, 1, 1, 1, 6'd30, 0, 1, 8'hEE, 1);
      idle(3, 1, 1);

      // Reset in the middle of DRAIN.
      step(1, 0, 1, 1, 6'd1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 6'd2, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 1, 8'h11, 0);
      step(1, 0, 1, 0, 0, 0, 1, 8'h22, 0);
      idle(4, 1, 0);
      do_reset();
      idle(4, 1, 1);

      // Mixed random traffic with occasional clear and reset.
      rand_steps(2500, 60, 60, 60, 90, 8, 3, 2);
      idle(40, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/row_router.md
Name: row_router

Overview:
- Per-row routing stage directly downstream of the data selector; one instance per systolic-array row, S_HEIGHT instances total.
- Holds the queue of buffer addresses that its row needs and presents the head address to the selector.
- On a selector hit, pops the address and captures the returned activation byte one cycle later into a data FIFO.
- The data FIFO is drained in order by the array row, and the block generates a stall to throttle the selector when the data FIFO would overflow.

Parameters:
- DATA_WIDTH, 8, width of one data element.
- BUF_DEPTH, 64, depth of the tile buffer. Localparam ADDR_WIDTH = $clog2(BUF_DEPTH).
- FIFO_DEPTH, 16, entries in each of the address FIFO and the data FIFO. Must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset, synchronous, active-low
- i_en  in  1  block enable
- i_reg_clear  in  1  synchronous clear of FIFOs, pending state and FSM
- i_addr_valid  in  1  address write request from address generator
- i_addr  in  ADDR_WIDTH  address to enqueue
- i_addr_last  in  1  tags i_addr as the final address of the tile
- o_addr_ready  out  1  address FIFO not full
- o_rr_valid_addr  out  1  address FIFO not empty; to selector valid-addr bit for this row
- o_rr_addr  out  ADDR_WIDTH  address FIFO head; to selector address for this row
- i_rr_data_hit  in  1  selector hit for this row (combinational, same cycle as o_rr_addr)
- i_rr_data  in  DATA_WIDTH  selector registered data for this row; valid the cycle after the hit
- o_stall  out  1  to selector stall input
- i_data_ready  in  1  array row pops the data FIFO
- o_data_valid  out  1  data FIFO not empty
- o_data  out  DATA_WIDTH  data FIFO head
- o_data_count  out  $clog2(FIFO_DEPTH)+1  data FIFO occupancy
- o_done  out  1  one-cycle pulse when the tile is fully routed and drained

Behaviour:
- Reset (i_nrst=0 at a clock edge) state:
  - Both FIFOs empty; hit_d1=0; last_seen=0; FSM in IDLE.
  - Outputs: o_addr_ready=1, o_rr_valid_addr=0, o_rr_addr=0, o_stall=1, o_data_valid=0, o_data=0, o_data_count=0, o_done=0.
  - Reset mid-operation discards all contents; nothing is flushed out.
- i_reg_clear=1 has the same effect as reset, except it has lower priority than i_nrst. It wins over all simultaneous push, pop and hit events.
- Address FIFO:
  - Push when i_addr_valid & o_addr_ready. The {addr, last} pair is stored together.
  - Pop when i_rr_data_hit & o_rr_valid_addr & ~o_stall.
  - Push and pop in the same cycle are allowed. When full, o_addr_ready=0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH. A full/empty extra bit distinguishes the two states.
  - o_rr_addr is the registered head value; it is 0 when empty.
- Hit pipeline:
  - hit_d1 <= pop. In the cycle where hit_d1=1, i_rr_data is pushed into the data FIFO unconditionally.
  - Hit-to-push latency is 1 cycle. Hit-to-o_data_valid latency is 2 cycles if the data FIFO was empty.
- Stall, combinational from registers: o_stall = ~i_en | (FSM != ROUTE) | (data_count + hit_d1 >= FIFO_DEPTH).
  - This guarantees a push never finds the data FIFO full.
  - A hit arriving while o_stall=1 is ignored: no pop, no push.
- Data FIFO:
  - Pop when i_data_ready & o_data_valid. Push and pop in the same cycle keep the count unchanged.
  - No bypass: data pushed at cycle t is visible at t+1.
  - i_data_ready while empty has no effect.
- Consecutive identical addresses are unsupported. The address generator must not enqueue them, because only the head is compared each cycle.
- FSM:
  - IDLE: go to ROUTE when i_en=1.
  - ROUTE:
    - last_seen <= 1 when an entry with last=1 is popped.
    - Go to DRAIN in the cycle after that pop, so its data push (hit_d1) completes.
    - i_en=0 holds the state, with o_stall=1.
  - DRAIN: no new hits accepted. When the data FIFO is empty, go to DONE.
  - DONE: o_done=1 for one cycle, last_seen cleared, then go to IDLE.
  - i_en deasserted in DRAIN does not block draining.

Decomposition:
- Shared package (router_pkg) holds:
  - the FSM state enum rr_state_t {IDLE, ROUTE, DRAIN, DONE};
  - the address FIFO entry struct rr_addr_entry_t {addr, last};
  - a function clog2-based width helper.
- One natural sub-module: sync_fifo (parameterised WIDTH/DEPTH; push, pop, full, empty, count). It is instantiated twice: once for addresses with WIDTH=ADDR_WIDTH+1, once for data.

Test Plan:
- Reset then i_en=1, enqueue addrs 3,7,9 (last on 9), hit each in successive cycles with data 0xA1,0xB2,0xC3 -> o_data sequence A1,B2,C3, each appearing 2 cycles after its hit; o_done pulses once after the final pop.
- Data FIFO at 15/16 with hit_d1=1, i_data_ready=0 -> o_stall=1; the hit that cycle is ignored and o_rr_addr is unchanged; one pop releases the stall the next cycle.
- Fill the address FIFO with 16 entries -> o_addr_ready=0; a 17th i_addr_valid is dropped; simultaneous pop plus push in the full cycle does not accept the push.
- Hit while i_en=0 (FSM in ROUTE) -> no pop, no push, o_stall=1; on re-enable routing resumes with the same head address.
- i_reg_clear asserted while 5 addresses and 4 data entries are held and a hit is pending -> next cycle both FIFOs are empty, o_data_valid=0, FSM is IDLE, and the pending data is not pushed.
- i_nrst low mid-DRAIN -> all outputs at reset values on the following cycle; o_done never pulses.
